// File: rtl/risc16_alu_arbiter.sv
// Round-robin arbiter sharing one RiSC16 ALU between two requesters, one response buffer each.
// Latency: request granted combinationally; its response is valid the cycle after acceptance.
// Backpressure: a full buffer that is not draining blocks its requester; drain plus accept keeps full rate.
module risc16_alu_arbiter #(
    parameter int WORD_LENGTH = 16,
    parameter int FUNCT_LEN   = 3,
    parameter logic [FUNCT_LEN-1:0] ALU_ADD = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [WORD_LENGTH-1:0] req0_src1,
    input  logic [WORD_LENGTH-1:0] req0_src2,
    input  logic [FUNCT_LEN-1:0]   req0_funct,
    input  logic [WORD_LENGTH-1:0] req1_src1,
    input  logic [WORD_LENGTH-1:0] req1_src2,
    input  logic [FUNCT_LEN-1:0]   req1_funct,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [WORD_LENGTH-1:0] rsp0_result,
    output logic                   rsp0_state,
    output logic [WORD_LENGTH-1:0] rsp1_result,
    output logic                   rsp1_state,
    output logic [WORD_LENGTH-1:0] alu_src1,
    output logic [WORD_LENGTH-1:0] alu_src2,
    output logic [FUNCT_LEN-1:0]   alu_funct,
    input  logic [WORD_LENGTH-1:0] alu_result,
    input  logic                   alu_state
);

    logic [1:0] eligible;
    logic [1:0] grant;
    logic [1:0] accept;
    logic       rr_last;

    // A full buffer may take a new result only when it is being drained in the same cycle.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = rr_last ? 2'b01 : 2'b10;
        end
    end

    assign req_ready = reset_n ? grant : 2'b00;
    assign accept    = req_valid & req_ready;

    always_comb begin
        alu_src1  = '0;
        alu_src2  = '0;
        alu_funct = ALU_ADD;
        if (req_ready[0]) begin
            alu_src1  = req0_src1;
            alu_src2  = req0_src2;
            alu_funct = req0_funct;
        end else if (req_ready[1]) begin
            alu_src1  = req1_src1;
            alu_src2  = req1_src2;
            alu_funct = req1_funct;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid   <= 2'b00;
            rsp0_result <= '0;
            rsp0_state  <= 1'b0;
            rsp1_result <= '0;
            rsp1_state  <= 1'b0;
            rr_last     <= 1'b1;
        end else begin
            if (accept[0]) begin
                rsp0_result  <= alu_result;
                rsp0_state   <= alu_state;
                rsp_valid[0] <= 1'b1;
            end else if (rsp_ready[0]) begin
                rsp_valid[0] <= 1'b0;
            end

            if (accept[1]) begin
                rsp1_result  <= alu_result;
                rsp1_state   <= alu_state;
                rsp_valid[1] <= 1'b1;
            end else if (rsp_ready[1]) begin
                rsp_valid[1] <= 1'b0;
            end

            if (accept[0]) begin
                rr_last <= 1'b0;
            end else if (accept[1]) begin
                rr_last <= 1'b1;
            end
        end
    end

endmodule
